// File: rtl/afe_seq_pkg.sv
// Shared opcodes and FSM state encoding for the AFE bring-up sequencer.
package afe_seq_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_STOP  = 4'd0;
  localparam logic [OPC_W-1:0] OP_SEND  = 4'd1;
  localparam logic [OPC_W-1:0] OP_DELAY = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_SEND,
    S_DELAY,
    S_FINISH
  } seq_state_e;

endpackage

// File: rtl/afe_init_sequencer_if.sv
// Command handshake between the init sequencer (master) and the SPI engine (slave).
interface afe_init_sequencer_if #(
  parameter int unsigned DATA_W = 20
);
  logic [DATA_W-1:0] spi_cmd;
  logic              spi_valid;
  logic              spi_ready;

  modport master (output spi_cmd, output spi_valid, input spi_ready);
  modport slave  (input spi_cmd, input spi_valid, output spi_ready);
endinterface

// File: rtl/afe_seq_table.sv
// Command table: registered address, combinational entry decode; unlisted entries read as STOP.
// USE_INIT replaces the built-in bring-up sequence with the packed INIT vector (entry i at slice i).
module afe_seq_table
  import afe_seq_pkg::*;
#(
  parameter int unsigned DATA_W   = 20,
  parameter int unsigned DEPTH    = 16,
  parameter bit          USE_INIT = 1'b0,
  parameter logic [DEPTH*(DATA_W+OPC_W)-1:0] INIT = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  output logic [DATA_W+OPC_W-1:0]    entry
);
  localparam int unsigned EW = DATA_W + OPC_W;

  logic [$clog2(DEPTH)-1:0] addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) addr_q <= '0;
    else          addr_q <= addr;
  end

  function automatic logic [EW-1:0] mk(input logic [OPC_W-1:0] op, input logic [19:0] pl);
    return {op, DATA_W'(pl)};
  endfunction

  always_comb begin
    entry = '0;
    if (USE_INIT) begin
      entry = INIT[int'(addr_q)*EW +: EW];
    end else begin
      case (int'(addr_q))
        0:       entry = mk(OP_SEND, 20'h20A0E);
        1:       entry = mk(OP_SEND, 20'h0DB01);
        2:       entry = mk(OP_SEND, 20'h0F208);
        3:       entry = mk(OP_SEND, 20'h30B80);
        4:       entry = mk(OP_SEND, 20'h30C04);
        5:       entry = mk(OP_SEND, 20'h33A82);
        default: entry = mk(OP_STOP, 20'h00000);
      endcase
    end
  end

endmodule

// File: rtl/afe_init_sequencer.sv
// AFE bring-up sequencer: walks a command table, issuing SPI words and timed waits.
// Optional DELAY opcode and counter built only when AFE_SEQ_DELAY_EN is defined.
module afe_init_sequencer
  import afe_seq_pkg::*;
#(
  parameter int unsigned DATA_W         = 20,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned DLY_W          = 16,
  parameter bit          TABLE_OVERRIDE = 1'b0,
  parameter logic [DEPTH*(DATA_W+OPC_W)-1:0] TABLE_INIT = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  afe_init_sequencer_if.master spi,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  localparam int unsigned AW = $clog2(DEPTH);

  if (DLY_W > DATA_W) begin : g_bad_dly_w
    $error("DLY_W must not exceed DATA_W");
  end

  seq_state_e               state, state_d;
  logic [AW-1:0]            addr, addr_d;
  logic [DATA_W-1:0]        cmd_q, cmd_d;
  logic                     err_q, err_d;
  logic [DATA_W+OPC_W-1:0]  entry;
  logic [OPC_W-1:0]         opcode;
  logic [DATA_W-1:0]        payload;
  logic                     last;
`ifdef AFE_SEQ_DELAY_EN
  logic [DLY_W-1:0]         cnt, cnt_d;
`endif

  afe_seq_table #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .USE_INIT (TABLE_OVERRIDE),
    .INIT     (TABLE_INIT)
  ) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .entry   (entry)
  );

  assign opcode  = entry[DATA_W+OPC_W-1 -: OPC_W];
  assign payload = entry[DATA_W-1:0];
  assign last    = (addr == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      addr  <= '0;
      cmd_q <= '0;
      err_q <= 1'b0;
`ifdef AFE_SEQ_DELAY_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_d;
      addr  <= addr_d;
      cmd_q <= cmd_d;
      err_q <= err_d;
`ifdef AFE_SEQ_DELAY_EN
      cnt   <= cnt_d;
`endif
    end
  end

  // Advancing past the last entry never wraps: it terminates with error.
  always_comb begin
    state_d = state;
    addr_d  = addr;
    cmd_d   = cmd_q;
    err_d   = err_q;
`ifdef AFE_SEQ_DELAY_EN
    cnt_d   = cnt;
`endif
    case (state)
      S_IDLE, S_FINISH: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_SEND: begin
            state_d = S_SEND;
            cmd_d   = payload;
          end
`ifdef AFE_SEQ_DELAY_EN
          OP_DELAY: begin
            state_d = S_DELAY;
            cnt_d   = payload[DLY_W-1:0];
          end
`endif
          OP_STOP: state_d = S_FINISH;
          default: begin
            state_d = S_FINISH;
            err_d   = 1'b1;
          end
        endcase
      end
      S_SEND: begin
        if (spi.spi_ready) begin
          if (last) begin
            state_d = S_FINISH;
            err_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
            addr_d  = addr + 1'b1;
          end
        end
      end
`ifdef AFE_SEQ_DELAY_EN
      S_DELAY: begin
        if (cnt <= DLY_W'(1)) begin
          if (last) begin
            state_d = S_FINISH;
            err_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
            addr_d  = addr + 1'b1;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign spi.spi_cmd   = cmd_q;
  assign spi.spi_valid = (state == S_SEND);
  assign busy          = (state == S_FETCH) || (state == S_EXEC) ||
                         (state == S_SEND)  || (state == S_DELAY);
  assign done          = (state == S_FINISH);
  assign error         = err_q;

endmodule

// File: tb/tb_afe_init_sequencer.sv
// Directed bench for afe_init_sequencer: default table, delay table and a DEPTH=4 table without STOP.
module tb_afe_init_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  logic m_start, d_start, n_start;
  logic m_busy, m_done, m_err;
  logic d_busy, d_done, d_err;
  logic n_busy, n_done, n_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  afe_init_sequencer_if #(.DATA_W(20)) m_if ();
  afe_init_sequencer_if #(.DATA_W(20)) d_if ();
  afe_init_sequencer_if #(.DATA_W(20)) n_if ();

  afe_init_sequencer u_main (
    .clk(clk), .reset_n(reset_n), .start(m_start), .spi(m_if.master),
    .busy(m_busy), .done(m_done), .error(m_err)
  );

  afe_init_sequencer #(
    .DEPTH(16), .TABLE_OVERRIDE(1'b1),
    .TABLE_INIT({{12{24'h0}}, 24'h0_00000, 24'h1_22222, 24'h2_0000A, 24'h1_11111})
  ) u_dly (
    .clk(clk), .reset_n(reset_n), .start(d_start), .spi(d_if.master),
    .busy(d_busy), .done(d_done), .error(d_err)
  );

  afe_init_sequencer #(
    .DEPTH(4), .TABLE_OVERRIDE(1'b1),
    .TABLE_INIT({24'h1_0000D, 24'h1_0000C, 24'h1_0000B, 24'h1_0000A})
  ) u_ns (
    .clk(clk), .reset_n(reset_n), .start(n_start), .spi(n_if.master),
    .busy(n_busy), .done(n_done), .error(n_err)
  );

  logic [19:0] exp_seq [6] = '{20'h20A0E, 20'h0DB01, 20'h0F208, 20'h30B80, 20'h30C04, 20'h33A82};
  logic [19:0] cap     [16];
  int          cyc     [16];
  int          ncap;
  int          nvalid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collects handshakes on one DUT until its done rises or the budget runs out.
  task automatic collect(input int sel, input int budget, output bit timed_out);
    logic v, r, dn;
    logic [19:0] c;
    ncap = 0; nvalid = 0; timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      v  = (sel == 0) ? m_if.spi_valid : (sel == 1) ? d_if.spi_valid : n_if.spi_valid;
      r  = (sel == 0) ? m_if.spi_ready : (sel == 1) ? d_if.spi_ready : n_if.spi_ready;
      c  = (sel == 0) ? m_if.spi_cmd   : (sel == 1) ? d_if.spi_cmd   : n_if.spi_cmd;
      dn = (sel == 0) ? m_done : (sel == 1) ? d_done : n_done;
      if (v) nvalid++;
      if (v && r && ncap < 16) begin
        cap[ncap] = c; cyc[ncap] = k; ncap++;
      end
      if (dn) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_start = 1'b0; d_start = 1'b0; n_start = 1'b0;
    m_if.spi_ready = 1'b0; d_if.spi_ready = 1'b0; n_if.spi_ready = 1'b0;
    tick(); tick();
    total++; if (m_if.spi_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_if.spi_valid); end
    total++; if (m_if.spi_cmd !== 20'h0) begin bad++; $display("FAIL reset_cmd got=%h exp=00000", m_if.spi_cmd); end
    total++; if ({m_busy, m_done, m_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {m_busy, m_done, m_err}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_sequence();
    bit to;
    m_if.spi_ready = 1'b1;
    m_start = 1'b1; tick(); m_start = 1'b0;
    total++; if ({m_busy, m_done} !== 2'b10) begin bad++; $display("FAIL seq_busy_after_start got=%b exp=10", {m_busy, m_done}); end
    collect(0, 100, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL seq_timeout got=%b exp=0", to); end
    total++; if (ncap !== 6) begin bad++; $display("FAIL seq_count got=%0d exp=6", ncap); end
    for (int i = 0; i < 6; i++) begin
      total++; if (cap[i] !== exp_seq[i]) begin bad++; $display("FAIL seq_cmd%0d got=%h exp=%h", i, cap[i], exp_seq[i]); end
    end
    for (int i = 0; i < 5; i++) begin
      total++; if (cyc[i+1] - cyc[i] !== 3) begin bad++; $display("FAIL seq_gap%0d got=%0d exp=3", i, cyc[i+1] - cyc[i]); end
    end
    total++; if ({m_done, m_err, m_busy} !== 3'b100) begin bad++; $display("FAIL seq_end_flags got=%b exp=100", {m_done, m_err, m_busy}); end
    for (int i = 0; i < 3; i++) tick();
    total++; if ({m_done, m_busy, m_if.spi_valid} !== 3'b100) begin bad++; $display("FAIL seq_finish_hold got=%b exp=100", {m_done, m_busy, m_if.spi_valid}); end
  endtask

  task automatic test_backpressure();
    bit to;
    int w;
    m_if.spi_ready = 1'b0;
    m_start = 1'b1; tick(); m_start = 1'b0;
    w = 0;
    while (!m_if.spi_valid && w < 10) begin tick(); w++; end
    total++; if (m_if.spi_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid got=%b exp=1", m_if.spi_valid); end
    for (int i = 0; i < 5; i++) begin
      total++; if ({m_if.spi_valid, m_if.spi_cmd} !== {1'b1, 20'h20A0E}) begin bad++; $display("FAIL bp_hold%0d got=%b/%h exp=1/20a0e", i, m_if.spi_valid, m_if.spi_cmd); end
      tick();
    end
    m_if.spi_ready = 1'b1;
    collect(0, 100, to);
    total++; if (ncap !== 6 || to) begin bad++; $display("FAIL bp_count got=%0d exp=6 (timeout=%b)", ncap, to); end
    total++; if (cap[0] !== 20'h20A0E || cap[1] !== 20'h0DB01) begin bad++; $display("FAIL bp_order got=%h,%h exp=20a0e,0db01", cap[0], cap[1]); end
  endtask

  task automatic test_delay();
    bit to;
    d_if.spi_ready = 1'b1;
    d_start = 1'b1; tick(); d_start = 1'b0;
    collect(1, 100, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL dly_timeout got=%b exp=0", to); end
`ifdef AFE_SEQ_DELAY_EN
    total++; if (ncap !== 2 || nvalid !== 2) begin bad++; $display("FAIL dly_count got=%0d/%0d exp=2/2", ncap, nvalid); end
    total++; if (cyc[1] - cyc[0] !== 15) begin bad++; $display("FAIL dly_gap got=%0d exp=15", cyc[1] - cyc[0]); end
    total++; if (cap[1] !== 20'h22222) begin bad++; $display("FAIL dly_second_cmd got=%h exp=22222", cap[1]); end
    total++; if ({d_done, d_err} !== 2'b10) begin bad++; $display("FAIL dly_end_flags got=%b exp=10", {d_done, d_err}); end
`else
    total++; if (ncap !== 1) begin bad++; $display("FAIL dly_count got=%0d exp=1", ncap); end
    total++; if ({d_done, d_err} !== 2'b11) begin bad++; $display("FAIL dly_reserved_flags got=%b exp=11", {d_done, d_err}); end
`endif
    total++; if (cap[0] !== 20'h11111) begin bad++; $display("FAIL dly_first_cmd got=%h exp=11111", cap[0]); end
  endtask

  task automatic test_no_stop();
    bit to;
    logic seen;
    logic [19:0] exp_ns [4] = '{20'h0000A, 20'h0000B, 20'h0000C, 20'h0000D};
    n_if.spi_ready = 1'b1;
    n_start = 1'b1; tick(); n_start = 1'b0;
    collect(2, 100, to);
    total++; if (ncap !== 4 || to) begin bad++; $display("FAIL ns_count got=%0d exp=4 (timeout=%b)", ncap, to); end
    for (int i = 0; i < 4; i++) begin
      total++; if (cap[i] !== exp_ns[i]) begin bad++; $display("FAIL ns_cmd%0d got=%h exp=%h", i, cap[i], exp_ns[i]); end
    end
    total++; if ({n_done, n_err} !== 2'b11) begin bad++; $display("FAIL ns_end_flags got=%b exp=11", {n_done, n_err}); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin seen |= n_if.spi_valid; tick(); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ns_fifth_valid got=%b exp=0", seen); end
    n_if.spi_ready = 1'b0;
    n_start = 1'b1; tick(); n_start = 1'b0;
    total++; if ({n_busy, n_done, n_err} !== 3'b100) begin bad++; $display("FAIL ns_restart_clear got=%b exp=100", {n_busy, n_done, n_err}); end
  endtask

  task automatic test_reset_mid_send();
    bit to;
    int sends;
    logic seen;
    m_if.spi_ready = 1'b1;
    m_start = 1'b1; tick(); m_start = 1'b0;
    sends = 0;
    for (int k = 0; k < 60 && sends < 3; k++) begin
      if (m_if.spi_valid) sends++;
      if (sends < 3) tick();
    end
    total++; if ({m_if.spi_valid, m_if.spi_cmd} !== {1'b1, 20'h0F208}) begin bad++; $display("FAIL rst_third_send got=%b/%h exp=1/0f208", m_if.spi_valid, m_if.spi_cmd); end
    #1 reset_n = 1'b0;
    #1;
    total++; if ({m_if.spi_valid, m_if.spi_cmd, m_busy, m_done, m_err} !== 24'h0) begin bad++; $display("FAIL rst_async_outputs got=%b/%h/%b%b%b exp=0/00000/000", m_if.spi_valid, m_if.spi_cmd, m_busy, m_done, m_err); end
    tick(); tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin seen |= m_if.spi_valid | m_busy; tick(); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_no_resume got=%b exp=0", seen); end
    m_start = 1'b1; tick(); m_start = 1'b0;
    collect(0, 100, to);
    total++; if (ncap !== 6 || to) begin bad++; $display("FAIL rst_rerun_count got=%0d exp=6 (timeout=%b)", ncap, to); end
    total++; if (cap[0] !== 20'h20A0E) begin bad++; $display("FAIL rst_rerun_first got=%h exp=20a0e", cap[0]); end
  endtask

  task automatic test_start_while_busy();
    bit to;
    m_if.spi_ready = 1'b1;
    m_start = 1'b1; tick(); m_start = 1'b0;
    ncap = 0; to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      m_start = (k == 4 || k == 9);
      if (m_if.spi_valid && m_if.spi_ready && ncap < 16) begin cap[ncap] = m_if.spi_cmd; ncap++; end
      if (m_done) begin to = 1'b0; break; end
      tick();
    end
    m_start = 1'b0;
    total++; if (ncap !== 6 || to) begin bad++; $display("FAIL busy_start_count got=%0d exp=6 (timeout=%b)", ncap, to); end
    for (int i = 0; i < 6; i++) begin
      total++; if (cap[i] !== exp_seq[i]) begin bad++; $display("FAIL busy_start_cmd%0d got=%h exp=%h", i, cap[i], exp_seq[i]); end
    end
    tick();
    m_start = 1'b1; tick(); m_start = 1'b0;
    total++; if ({m_busy, m_done, m_err} !== 3'b100) begin bad++; $display("FAIL finish_start_clear got=%b exp=100", {m_busy, m_done, m_err}); end
    collect(0, 100, to);
    total++; if (ncap !== 6 || to || cap[5] !== 20'h33A82) begin bad++; $display("FAIL finish_rerun got=%0d/%h exp=6/33a82", ncap, cap[5]); end
    total++; if ({m_done, m_err} !== 2'b10) begin bad++; $display("FAIL finish_rerun_flags got=%b exp=10", {m_done, m_err}); end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_backpressure();
    test_delay();
    test_no_stop();
    test_reset_mid_send();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afe_init_sequencer.md
AFE_INIT_SEQUENCER -- requirements
Module: afe_init_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 20, meaning SPI command word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of table entries (power of two, >=2).
REQ-003 SHALL have parameter DLY_W, default 16, meaning delay-count width (DLY_W <= DATA_W).
REQ-004 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to run the table from entry 0.
REQ-007 SHALL have port spi_cmd  output  DATA_W  command word to SPI master.
REQ-008 SHALL have port spi_valid  output  1  spi_cmd is valid.
REQ-009 SHALL have port spi_ready  input  1  SPI master accepts spi_cmd this cycle.
REQ-010 SHALL have ports busy, done, error  output  1 each; sequence running / finished / malformed table.

Function
REQ-011 Table entry SHALL be {opcode[3:0], payload[DATA_W-1:0]}; opcode 0 STOP, 1 SEND, 2 DELAY (payload[DLY_W-1:0] cycles), others reserved.
REQ-012 FSM SHALL have states IDLE, FETCH, EXEC, SEND, DELAY, FINISH.
REQ-013 IDLE or FINISH + start=1 SHALL go to FETCH next cycle with address 0, done and error cleared, busy=1.
REQ-014 FETCH SHALL last exactly one cycle (registered table address), then EXEC.
REQ-015 EXEC SHALL decode: SEND -> SEND state, DELAY -> DELAY state loading counter, STOP -> FINISH, reserved -> FINISH with error=1.
REQ-016 In SEND, spi_valid SHALL be 1 and spi_cmd stable until the cycle spi_valid & spi_ready, then address increments and FSM enters FETCH.
REQ-017 spi_cmd SHALL be registered, asserted no earlier than the cycle after EXEC; spi_valid SHALL never drop before handshake.
REQ-018 DELAY SHALL count down payload cycles; payload 0 SHALL leave after one cycle; on zero, address increments, FETCH.
REQ-019 Executing entry DEPTH-1 without STOP SHALL end in FINISH with error=1 (no address wrap).
REQ-020 FINISH SHALL hold done=1, busy=0 until next start.
REQ-021 start while busy SHALL be ignored.
REQ-022 Send-to-send throughput SHALL be 3 cycles minimum (FETCH, EXEC, SEND with ready=1).

Reset
REQ-023 reset_n low SHALL force IDLE, address 0, counter 0, spi_cmd 0, spi_valid 0, busy 0, done 0, error 0, asynchronously.
REQ-024 Reset mid-SEND SHALL drop spi_valid immediately; no command resumes after reset release without start.

Configuration
REQ-025 Macro AFE_SEQ_DELAY_EN defined: DELAY opcode and counter SHALL be implemented per REQ-018.
REQ-026 Macro undefined: counter SHALL be absent and opcode 2 SHALL be treated as reserved (FINISH, error=1).

Structure
REQ-027 Opcode localparams (OP_STOP, OP_SEND, OP_DELAY) and FSM state encoding SHALL live in shared package afe_seq_pkg.
REQ-028 Table SHALL be sub-module afe_seq_table (registered address, combinational case on data, DEPTH x (DATA_W+4)), unlisted entries returning STOP.
REQ-029 Default table SHALL hold the existing AFE bring-up sequence: 20A0E, 0DB01, 0F208, 30B80, 30C04, 33A82, STOP.

Verification
REQ-030 Reset, start pulse, spi_ready tied 1 -> six handshakes with spi_cmd 0x20A0E..0x33A82 in order, then done=1, error=0.
REQ-031 spi_ready low 5 cycles on first command -> spi_valid=1, spi_cmd=0x20A0E held all 5 cycles, single transfer counted.
REQ-032 Table entry DELAY 10 between two SENDs (macro defined) -> exactly 10 DELAY cycles, no spi_valid; macro undefined -> error=1 at that entry.
REQ-033 Table without STOP, DEPTH=4 -> four sends, then done=1, error=1, no fifth spi_valid.
REQ-034 reset_n asserted during third SEND -> all outputs 0 same cycle; start after release -> sequence restarts at 0x20A0E.
REQ-035 start pulsed while busy and again in FINISH -> first ignored, second reruns full sequence with done cleared.
